load_dma_buffer: RTL and testbench

// Parametrised DRAM-to-SRAM load engine. Accepts one load command, issues one AXI

---
 rtl/load_dma_buffer_if.sv | 66 ++++++
 rtl/load_dma_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_load_dma_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_dma_buffer_if.sv
// Bundle of the load engine's command, AXI read (AR/R), SRAM write and completion
// signals. "master" is the engine's view; "slave" is the surrounding system's view
// (control unit, AXI interconnect and SRAM wrapper together).
interface load_dma_buffer_if #(
   parameter int DATA_W  = 32,
   parameter int DRAM_AW = 12,
   parameter int SRAM_AW = 8,
   parameter int ID_W    = 8,
   parameter int STR_W   = 3
);
   // command side
   logic                  cmd_vld;
   logic                  cmd_rdy;
   logic [ID_W-1:0]       cmd_id;
   logic [DRAM_AW-1:0]    cmd_dram_addr;
   logic [7:0]            cmd_len;
   logic [2:0]            cmd_size;
   logic [SRAM_AW-1:0]    cmd_sram_addr;
   logic [STR_W-1:0]      cmd_sram_str;
   // AXI read address channel
   logic                  axi_arvld;
   logic                  axi_arrdy;
   logic [ID_W-1:0]       axi_arid;
   logic [DRAM_AW-1:0]    axi_araddr;
   logic [7:0]            axi_arlen;
   logic [2:0]            axi_arsize;
   logic [1:0]            axi_arburst;
   // AXI read data channel
   logic                  axi_rvld;
   logic                  axi_rrdy;
   logic [ID_W-1:0]       axi_rid;
   logic [DATA_W-1:0]     axi_rdata;
   logic [1:0]            axi_rresp;
   logic                  axi_rlast;
   // SRAM write port
   logic                  sram_vld;
   logic [DATA_W/8-1:0]   sram_wen;
   logic [SRAM_AW-1:0]    sram_addr;
   logic [DATA_W-1:0]     sram_din;
   // completion / status
   logic                  done_vld;
   logic                  done_err;
   logic                  busy;

   modport master (
      input  cmd_vld, cmd_id, cmd_dram_addr, cmd_len, cmd_size, cmd_sram_addr, cmd_sram_str,
      output cmd_rdy,
      output axi_arvld, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
      input  axi_arrdy,
      input  axi_rvld, axi_rid, axi_rdata, axi_rresp, axi_rlast,
      output axi_rrdy,
      output sram_vld, sram_wen, sram_addr, sram_din,
      output done_vld, done_err, busy
   );

   modport slave (
      output cmd_vld, cmd_id, cmd_dram_addr, cmd_len, cmd_size, cmd_sram_addr, cmd_sram_str,
      input  cmd_rdy,
      input  axi_arvld, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
      output axi_arrdy,
      output axi_rvld, axi_rid, axi_rdata, axi_rresp, axi_rlast,
      input  axi_rrdy,
      input  sram_vld, sram_wen, sram_addr, sram_din,
      input  done_vld, done_err, busy
   );
endinterface

// File: rtl/load_dma_buffer.sv
// DRAM-to-SRAM load engine: takes one command, issues a single AXI INCR read burst,
// writes each good beat into SRAM at a strided word address and pulses done.
// An errored or short burst is re-issued from scratch up to MAX_RETRY times.
module load_dma_buffer #(
   parameter int DATA_W    = 32,
   parameter int DRAM_AW   = 12,
   parameter int SRAM_AW   = 8,
   parameter int ID_W      = 8,
   parameter int STR_W     = 3,
   parameter int MAX_RETRY = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   load_dma_buffer_if.master  bus
);
   // retry counter must hold values 0..MAX_RETRY; keep at least one bit
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_AR    = 2'd1,
      S_RDATA = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_reg;
   state_t               state_next;

   // latched command
   logic [ID_W-1:0]      id_reg;
   logic [DRAM_AW-1:0]   dram_addr_reg;
   logic [7:0]           len_reg;
   logic [2:0]           size_reg;
   logic [SRAM_AW-1:0]   sram_base_reg;
   logic [STR_W-1:0]     str_reg;

   // per-burst / per-command progress
   logic [RW-1:0]        retry_cnt_reg;
   logic [8:0]           beat_cnt_reg;   // counts matching beats, saturates at len+1
   logic                 err_reg;
   logic [SRAM_AW-1:0]   ptr_reg;

   // registered SRAM write port
   logic                 sram_vld_reg;
   logic [SRAM_AW-1:0]   sram_addr_reg;
   logic [DATA_W-1:0]    sram_din_reg;

   // beat decode
   logic [8:0]           len_ext;
   logic                 beat_fire;
   logic                 beat_match;
   logic                 beat_in_range;
   logic                 beat_write;
   logic                 beat_overrun;
   logic                 beat_short;
   logic                 burst_end;
   logic                 err_upd;
   logic                 retry_ok;

   // classify the current R beat and work out the error state it leaves behind
   always_comb begin
      len_ext       = {1'b0, len_reg};
      beat_fire     = (state_reg == S_RDATA) && bus.axi_rvld;
      beat_match    = beat_fire && (bus.axi_rid == id_reg);
      beat_in_range = (beat_cnt_reg <= len_ext);
      // only clean beats of a still-clean burst reach the SRAM
      beat_write    = beat_match && !bus.axi_rresp[1] && !err_reg && beat_in_range;
      // last legal beat index reached without rlast, or beats beyond it
      beat_overrun  = beat_match && !bus.axi_rlast && (beat_cnt_reg >= len_ext);
      // rlast arriving on any index other than len
      beat_short    = beat_match && bus.axi_rlast && (beat_cnt_reg != len_ext);
      burst_end     = beat_match && bus.axi_rlast;
      err_upd       = err_reg || (beat_match && bus.axi_rresp[1]) || beat_overrun || beat_short;
      retry_ok      = ({{(32-RW){1'b0}}, retry_cnt_reg} < 32'(MAX_RETRY));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.cmd_vld) begin
               state_next = S_AR;
            end
         end
         S_AR: begin
            if (bus.axi_arrdy) begin
               state_next = S_RDATA;
            end
         end
         S_RDATA: begin
            if (burst_end) begin
               state_next = (err_upd && retry_ok) ? S_AR : S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // state-decoded handshake and status outputs
   always_comb begin
      bus.cmd_rdy   = (state_reg == S_IDLE);
      bus.axi_arvld = (state_reg == S_AR);
      bus.axi_rrdy  = (state_reg == S_RDATA);
      bus.done_vld  = (state_reg == S_DONE);
      bus.done_err  = (state_reg == S_DONE) && err_reg;
      bus.busy      = (state_reg != S_IDLE);
   end

   // latch the command once, in IDLE, so AR fields stay stable across retries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_reg        <= '0;
         dram_addr_reg <= '0;
         len_reg       <= '0;
         size_reg      <= '0;
         sram_base_reg <= '0;
         str_reg       <= '0;
      end else if ((state_reg == S_IDLE) && bus.cmd_vld) begin
         id_reg        <= bus.cmd_id;
         dram_addr_reg <= bus.cmd_dram_addr;
         len_reg       <= bus.cmd_len;
         size_reg      <= bus.cmd_size;
         sram_base_reg <= bus.cmd_sram_addr;
         str_reg       <= bus.cmd_sram_str;
      end
   end

   // burst progress: beat count, error flag, SRAM pointer and retry count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt_reg <= '0;
         beat_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         ptr_reg       <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.cmd_vld) begin
                  retry_cnt_reg <= '0;
               end
            end
            S_AR: begin
               // every (re-)issue restarts the burst from the command's base
               beat_cnt_reg <= '0;
               err_reg      <= 1'b0;
               ptr_reg      <= sram_base_reg;
            end
            S_RDATA: begin
               if (beat_match) begin
                  err_reg <= err_upd;
                  if (beat_in_range) begin
                     beat_cnt_reg <= beat_cnt_reg + 9'd1;
                  end
               end
               if (beat_write) begin
                  // pointer wraps naturally modulo 2^SRAM_AW
                  ptr_reg <= ptr_reg + SRAM_AW'(str_reg);
               end
               if (burst_end && err_upd && retry_ok) begin
                  retry_cnt_reg <= retry_cnt_reg + RW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // one-cycle registered SRAM write of each accepted clean beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_vld_reg  <= 1'b0;
         sram_addr_reg <= '0;
         sram_din_reg  <= '0;
      end else begin
         sram_vld_reg <= beat_write;
         if (beat_write) begin
            sram_addr_reg <= ptr_reg;
            sram_din_reg  <= bus.axi_rdata;
         end
      end
   end

   assign bus.sram_vld    = sram_vld_reg;
   assign bus.sram_wen    = {(DATA_W/8){sram_vld_reg}};
   assign bus.sram_addr   = sram_addr_reg;
   assign bus.sram_din    = sram_din_reg;

   assign bus.axi_arid    = id_reg;
   assign bus.axi_araddr  = dram_addr_reg;
   assign bus.axi_arlen   = len_reg;
   assign bus.axi_arsize  = size_reg;
   assign bus.axi_arburst = 2'b01;
endmodule

// File: tb/tb_load_dma_buffer.sv
// Bench for load_dma_buffer: directed cases followed by randomized commands. Each
// command's expected SRAM writes and done status are derived from a per-attempt
// burst plan and queued; a separate monitor pops and compares as the DUT writes.
module tb_load_dma_buffer;
   localparam int DATA_W    = 32;
   localparam int DRAM_AW   = 12;
   localparam int SRAM_AW   = 8;
   localparam int ID_W      = 8;
   localparam int STR_W     = 3;
   localparam int MAX_RETRY = 2;

   localparam int K_OK    = 0;   // full burst, all OKAY/EXOKAY
   localparam int K_ERR   = 1;   // SLVERR/DECERR on beat j
   localparam int K_SHORT = 2;   // rlast on beat j < len

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   load_dma_buffer_if #(.DATA_W(DATA_W), .DRAM_AW(DRAM_AW), .SRAM_AW(SRAM_AW),
                        .ID_W(ID_W), .STR_W(STR_W)) bus ();

   load_dma_buffer #(.DATA_W(DATA_W), .DRAM_AW(DRAM_AW), .SRAM_AW(SRAM_AW),
                     .ID_W(ID_W), .STR_W(STR_W), .MAX_RETRY(MAX_RETRY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_wr_q[$];
   bit   exp_done_q[$];
   int   n_vec = 0;
   int   n_mis = 0;
   bit   abort = 1'b0;

   // burst plan for the current command, one entry per AR attempt
   int          plan_n;
   int          plan_kind [3];
   int          plan_j    [3];
   logic [31:0] plan_data [3][16];

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         fail(name, act, exp);
      end else begin
         n_vec++;
      end
   endtask

   task automatic timeout(input string name);
      fail({name, "_timeout"}, 64'd0, 64'd1);
      abort = 1'b1;
   endtask

   // scoreboard monitor: compare every SRAM write and done pulse against the queues
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.sram_vld) begin
            if (exp_wr_q.size() == 0) begin
               fail("sram_unexpected", {56'd0, bus.sram_addr}, 64'd0);
            end else begin
               wr_t w;
               w = exp_wr_q.pop_front();
               $display("sram write addr=%02h data=%08h", bus.sram_addr, bus.sram_din);
               chk("sram_addr", bus.sram_addr, w.addr);
               chk("sram_data", bus.sram_din, w.data);
               chk("sram_wen", bus.sram_wen, 4'hF);
            end
         end
         if (bus.done_vld) begin
            if (exp_done_q.size() == 0) begin
               fail("done_unexpected", {63'd0, bus.done_err}, 64'd0);
            end else begin
               bit e;
               e = exp_done_q.pop_front();
               $display("done err=%0d", bus.done_err);
               chk("done_err", bus.done_err, e);
               chk("done_writes_pending", exp_wr_q.size(), 0);
            end
         end
      end
   end

   task automatic fill_data();
      for (int a = 0; a < 3; a++)
         for (int k = 0; k < 16; k++)
            plan_data[a][k] = $urandom;
   endtask

   task automatic set_plan(input int n, input int k0, input int j0, input int k1,
                           input int j1, input int k2, input int j2);
      plan_n = n;
      plan_kind[0] = k0; plan_j[0] = j0;
      plan_kind[1] = k1; plan_j[1] = j1;
      plan_kind[2] = k2; plan_j[2] = j2;
      fill_data();
   endtask

   // random plan: attempts continue until a clean burst or retries are exhausted
   task automatic rand_plan(input int len);
      plan_n = 0;
      for (int a = 0; a <= MAX_RETRY; a++) begin
         int k;
         k = ($urandom_range(0, 1) == 0) ? K_OK : int'($urandom_range(1, 2));
         if (k == K_SHORT && len == 0) k = K_ERR;
         plan_kind[a] = k;
         plan_j[a]    = (k == K_SHORT) ? int'($urandom_range(0, len - 1)) : int'($urandom_range(0, len));
         plan_n++;
         if (k == K_OK) break;
      end
      fill_data();
   endtask

   task automatic send_beat(input logic [7:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
      int t;
      bus.axi_rid   = id;
      bus.axi_rdata = data;
      bus.axi_rresp = resp;
      bus.axi_rlast = last;
      bus.axi_rvld  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.axi_rrdy && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!bus.axi_rrdy) begin
         timeout("rrdy");
      end else begin
         chk("cmd_rdy_busy", bus.cmd_rdy, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.axi_rvld  = 1'b0;
      bus.axi_rlast = 1'b0;
   endtask

   // accept one AR after 'stall' cycles, checking it holds steady meanwhile
   task automatic accept_ar(input logic [7:0] id, input logic [11:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input int stall);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.axi_arvld && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.axi_arvld) begin
         timeout("arvld");
         return;
      end
      for (int s = 0; s < stall; s++) begin
         chk("arvld_held", bus.axi_arvld, 1'b1);
         chk("araddr_stable", bus.axi_araddr, addr);
         chk("arlen_stable", bus.axi_arlen, len);
         chk("rrdy_during_ar", bus.axi_rrdy, 1'b0);
         @(negedge clk);
      end
      chk("arid", bus.axi_arid, id);
      chk("araddr", bus.axi_araddr, addr);
      chk("arlen", bus.axi_arlen, len);
      chk("arsize", bus.axi_arsize, size);
      chk("arburst", bus.axi_arburst, 2'b01);
      bus.axi_arrdy = 1'b1;
      @(posedge clk);
      #1;
      bus.axi_arrdy = 1'b0;
   endtask

   task automatic issue_cmd(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [7:0] sram, input logic [2:0] str);
      @(posedge clk);
      #1;
      bus.cmd_id        = id;
      bus.cmd_dram_addr = addr;
      bus.cmd_len       = len;
      bus.cmd_size      = size;
      bus.cmd_sram_addr = sram;
      bus.cmd_sram_str  = str;
      bus.cmd_vld       = 1'b1;
      @(negedge clk);
      chk("cmd_rdy_idle", bus.cmd_rdy, 1'b1);
      @(posedge clk);
      #1;
      bus.cmd_vld       = 1'b0;
      bus.cmd_dram_addr = 12'($urandom);
      bus.cmd_len       = 8'($urandom);
      bus.cmd_sram_addr = 8'($urandom);
   endtask

   task automatic run_cmd(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [7:0] sram, input logic [2:0] str,
                          input int stall0);
      int L;
      int t;
      L = int'(len);
      $display("cmd id=%02h addr=%03h len=%0d sram=%02h str=%0d attempts=%0d",
               id, addr, len, sram, str, plan_n);
      // reference model: which beats of each attempt land in SRAM, and where
      for (int a = 0; a < plan_n; a++) begin
         int nwr;
         nwr = (plan_kind[a] == K_OK)  ? L + 1 :
               (plan_kind[a] == K_ERR) ? plan_j[a] : plan_j[a] + 1;
         for (int k = 0; k < nwr; k++) begin
            wr_t w;
            w.addr = 8'((int'(sram) + k * int'(str)) % 256);
            w.data = plan_data[a][k];
            exp_wr_q.push_back(w);
         end
      end
      exp_done_q.push_back(plan_kind[plan_n - 1] != K_OK);

      issue_cmd(id, addr, len, size, sram, str);
      for (int a = 0; a < plan_n; a++) begin
         int nb;
         accept_ar(id, addr, len, size, (a == 0) ? stall0 : int'($urandom_range(0, 3)));
         if (abort) return;
         nb = (plan_kind[a] == K_SHORT) ? plan_j[a] + 1 : L + 1;
         for (int k = 0; k < nb; k++) begin
            logic [1:0] resp;
            int gap;
            if ($urandom_range(0, 3) == 0) begin
               send_beat(id ^ 8'($urandom_range(1, 255)), $urandom, 2'($urandom),
                         1'($urandom));
               if (abort) return;
            end
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
               bus.cmd_vld       = 1'($urandom);
               bus.cmd_dram_addr = 12'($urandom);
               @(posedge clk);
               #1;
            end
            bus.cmd_vld = 1'b0;
            if (plan_kind[a] == K_ERR && k == plan_j[a])
               resp = {1'b1, 1'($urandom)};
            else if (plan_kind[a] == K_ERR && k > plan_j[a])
               resp = 2'($urandom);
            else
               resp = {1'b0, 1'($urandom)};
            send_beat(id, plan_data[a][k], resp, k == nb - 1);
            if (abort) return;
         end
      end
      t = 0;
      @(negedge clk);
      while (!bus.done_vld && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!bus.done_vld) begin
         timeout("done");
         return;
      end
      @(negedge clk);
      chk("cmd_rdy_after_done", bus.cmd_rdy, 1'b1);
      chk("busy_after_done", bus.busy, 1'b0);
      chk("no_extra_ar", bus.axi_arvld, 1'b0);
   endtask

   // reset in the middle of a burst: outputs clear at once, engine accepts again after
   task automatic reset_mid_burst();
      wr_t w;
      $display("cmd reset mid-burst");
      set_plan(1, K_OK, 0, K_OK, 0, K_OK, 0);
      w.addr = 8'h40;
      w.data = plan_data[0][0];
      exp_wr_q.push_back(w);
      issue_cmd(8'h5A, 12'h300, 8'd7, 3'd2, 8'h40, 3'd1);
      accept_ar(8'h5A, 12'h300, 8'd7, 3'd2, 0);
      if (abort) return;
      send_beat(8'h5A, plan_data[0][0], 2'b00, 1'b0);
      send_beat(8'h5A, plan_data[0][1], 2'b00, 1'b0);
      if (abort) return;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sram_vld", bus.sram_vld, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_arvld", bus.axi_arvld, 1'b0);
      chk("rst_rrdy", bus.axi_rrdy, 1'b0);
      chk("rst_done_vld", bus.done_vld, 1'b0);
      chk("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_rdy_after_rst", bus.cmd_rdy, 1'b1);
   endtask

   initial begin
      rst_n             = 1'b0;
      bus.cmd_vld       = 1'b0;
      bus.cmd_id        = '0;
      bus.cmd_dram_addr = '0;
      bus.cmd_len       = '0;
      bus.cmd_size      = '0;
      bus.cmd_sram_addr = '0;
      bus.cmd_sram_str  = '0;
      bus.axi_arrdy     = 1'b0;
      bus.axi_rvld      = 1'b0;
      bus.axi_rid       = '0;
      bus.axi_rdata     = '0;
      bus.axi_rresp     = '0;
      bus.axi_rlast     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_rdy", bus.cmd_rdy, 1'b1);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_arvld", bus.axi_arvld, 1'b0);
      chk("reset_rrdy", bus.axi_rrdy, 1'b0);
      chk("reset_sram_vld", bus.sram_vld, 1'b0);
      chk("reset_done_vld", bus.done_vld, 1'b0);
      chk("reset_araddr", bus.axi_araddr, 12'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // directed cases
      set_plan(1, K_OK, 0, K_OK, 0, K_OK, 0);
      plan_data[0][0] = 32'hD0; plan_data[0][1] = 32'hD1;
      plan_data[0][2] = 32'hD2; plan_data[0][3] = 32'hD3;
      run_cmd(8'h11, 12'h100, 8'd3, 3'd2, 8'h10, 3'd1, 5);
      if (!abort) begin
         set_plan(1, K_OK, 0, K_OK, 0, K_OK, 0);
         run_cmd(8'h22, 12'h200, 8'd2, 3'd2, 8'hFE, 3'd2, 0);
      end
      if (!abort) begin
         set_plan(2, K_ERR, 1, K_OK, 0, K_OK, 0);
         run_cmd(8'h33, 12'h040, 8'd3, 3'd2, 8'h20, 3'd1, 1);
      end
      if (!abort) begin
         set_plan(3, K_ERR, 1, K_ERR, 0, K_ERR, 3);
         run_cmd(8'h44, 12'h080, 8'd3, 3'd2, 8'h30, 3'd1, 0);
      end
      if (!abort) begin
         set_plan(2, K_SHORT, 1, K_OK, 0, K_OK, 0);
         run_cmd(8'h55, 12'h0C0, 8'd3, 3'd2, 8'h50, 3'd3, 2);
      end
      if (!abort) begin
         set_plan(1, K_OK, 0, K_OK, 0, K_OK, 0);
         run_cmd(8'h66, 12'h010, 8'd4, 3'd2, 8'h77, 3'd0, 0);
      end
      if (!abort) reset_mid_burst();
      if (!abort) begin
         set_plan(1, K_OK, 0, K_OK, 0, K_OK, 0);
         run_cmd(8'h77, 12'h400, 8'd1, 3'd2, 8'h00, 3'd1, 0);
      end

      // randomized commands
      for (int c = 0; c < 40 && !abort; c++) begin
         logic [7:0] len;
         len = 8'($urandom_range(0, 15));
         rand_plan(int'(len));
         run_cmd(8'($urandom), 12'($urandom), len, 3'($urandom), 8'($urandom),
                 3'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      chk("writes_left", exp_wr_q.size(), 0);
      chk("dones_left", exp_done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
